lp805x_rstctl: RTL and testbench

//  System reset controller for the lp805x core. Arbitrates all reset requests:
//   - power-on/raw reset
//   - external reset pin
//   - watchdog reset event pulse
//   - software reset via SFR

---
 rtl/lp805x_rstctl_pkg.sv | 29 ++
 rtl/lp805x_sync.sv | 23 ++
 rtl/lp805x_rstctl.sv | 145 ++++++++++++++
 tb/tb_lp805x_rstctl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lp805x_rstctl_pkg.sv
// Shared constants, RSTCON bit map and FSM state type for the lp805x reset controller.
package lp805x_rstctl_pkg;

    localparam logic [7:0]  LP805X_SFR_RSTCON  = 8'ha4;
    localparam int unsigned LP805X_STRETCH_DEF = 16;
    localparam int unsigned LP805X_STAGGER_DEF = 4;
    localparam int unsigned LP805X_RCNT_DEF    = 5;
    localparam int unsigned LP805X_SYNC_DEF    = 2;

    localparam int unsigned RSTCON_POR  = 0;
    localparam int unsigned RSTCON_EXT  = 1;
    localparam int unsigned RSTCON_WDT  = 2;
    localparam int unsigned RSTCON_SW   = 3;
    localparam int unsigned RSTCON_MULT = 4;

    localparam logic [2:0] LP805X_SW_KEY = 3'b101;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_HOLD  = 2'b01,
        ST_STAGE = 2'b10
    } rst_state_e;

    // True when at least two of the three request sources fire together.
    function automatic logic multi_src(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/lp805x_sync.sv
// N-flop synchronizer with asynchronous active-high reset.
module lp805x_sync #(
    parameter int unsigned N = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [N-1:0] r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= '0;
        end else begin
            r_q <= (r_q << 1) | N'(i_d);
        end
    end

    assign o_q = r_q[N-1];

endmodule

// File: rtl/lp805x_rstctl.sv
// lp805x reset controller: request arbitration, reset stretch with staged
// release (peripherals before CPU), and the sticky RSTCON cause register.
module lp805x_rstctl
    import lp805x_rstctl_pkg::*;
#(
    parameter logic [7:0]  LP805X_RSTCON_ADDR = LP805X_SFR_RSTCON,
    parameter int unsigned LP805X_STRETCH_LEN = LP805X_STRETCH_DEF,
    parameter int unsigned LP805X_STAGGER_LEN = LP805X_STAGGER_DEF,
    parameter int unsigned LP805X_RCNT_LEN    = LP805X_RCNT_DEF,
    parameter int unsigned LP805X_SYNC_LEN    = LP805X_SYNC_DEF
) (
    input  logic       clk,
    input  logic       rsti,
    input  logic       ext_rst_req,
    input  logic       wdt_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] rd_addr,
    input  logic [7:0] data_in,
    input  logic       bit_in,
    input  logic       wr,
    input  logic       rd,
    input  logic       wr_bit,
    input  logic       rd_bit,
    output logic [7:0] data_out,
    output logic       bit_out,
    output logic       rst_per,
    output logic       rst_cpu
);

    localparam logic [LP805X_RCNT_LEN-1:0] STRETCH_LAST = LP805X_RCNT_LEN'(LP805X_STRETCH_LEN - 1);
    localparam logic [LP805X_RCNT_LEN-1:0] STAGGER_LAST = LP805X_RCNT_LEN'(LP805X_STAGGER_LEN - 1);

    logic                       w_ext_s;
    logic                       w_cfg_wr;
    logic                       w_sw_req;
    logic [2:0]                 w_src;
    logic                       w_req;
    rst_state_e                 r_state;
    rst_state_e                 w_state_nxt;
    logic [LP805X_RCNT_LEN-1:0] r_cnt;
    logic [LP805X_RCNT_LEN-1:0] w_cnt_nxt;
    logic                       r_rst_per;
    logic                       r_rst_cpu;
    logic [4:0]                 r_rstcon;
    logic [4:0]                 w_set;
    logic [4:0]                 w_clr;
    logic                       r_rd_valid;
    logic [7:0]                 r_rd_data;
    logic                       w_unused;

    lp805x_sync #(.N(LP805X_SYNC_LEN)) u_ext_sync (
        .i_clk (clk),
        .i_rst (rsti),
        .i_d   (ext_rst_req),
        .o_q   (w_ext_s)
    );

    assign w_cfg_wr = wr & ~wr_bit & (wr_addr == LP805X_RSTCON_ADDR);
    assign w_sw_req = w_cfg_wr & (data_in[7:5] == LP805X_SW_KEY);
    assign w_src    = {w_sw_req, wdt_req, w_ext_s};
    assign w_req    = |w_src;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_RUN: begin
                if (w_req) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = '0;
                end
            end
            ST_HOLD: begin
                if (w_req) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == STRETCH_LAST) begin
                    w_state_nxt = ST_STAGE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_STAGE: begin
                if (w_req) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == STAGGER_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_HOLD;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs decode the next state so they change on the same edge as the FSM.
    always_ff @(posedge clk or posedge rsti) begin
        if (rsti) begin
            r_state   <= ST_HOLD;
            r_cnt     <= '0;
            r_rst_per <= 1'b1;
            r_rst_cpu <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rst_per <= (w_state_nxt == ST_HOLD);
            r_rst_cpu <= (w_state_nxt != ST_RUN);
        end
    end

    always_comb begin
        w_set              = '0;
        w_set[RSTCON_EXT]  = w_ext_s;
        w_set[RSTCON_WDT]  = wdt_req;
        w_set[RSTCON_SW]   = w_sw_req;
        w_set[RSTCON_MULT] = multi_src(w_src) | (w_req & (|r_rstcon[3:0]));
        w_clr              = (w_cfg_wr & ~w_sw_req) ? data_in[4:0] : '0;
    end

    always_ff @(posedge clk or posedge rsti) begin
        if (rsti) begin
            r_rstcon   <= 5'(1 << RSTCON_POR);
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rstcon <= (r_rstcon & ~w_clr) | w_set;
            if (rd) begin
                r_rd_valid <= (rd_addr == LP805X_RSTCON_ADDR);
                r_rd_data  <= (rd_addr == LP805X_RSTCON_ADDR) ? {3'b000, r_rstcon} : '0;
            end
        end
    end

    assign data_out = r_rd_valid ? r_rd_data : 'z;
    assign bit_out  = 1'bz;
    assign rst_per  = r_rst_per;
    assign rst_cpu  = r_rst_cpu;
    assign w_unused = ^{bit_in, rd_bit};

endmodule

// File: tb/tb_lp805x_rstctl.sv
// Self-checking bench for lp805x_rstctl: directed scenarios plus randomized traffic
// against a cycles-since-last-request reference model.
module tb_lp805x_rstctl;

    logic       clk = 1'b0;
    logic       rsti;
    logic       ext_rst_req;
    logic       wdt_req;
    logic [7:0] wr_addr;
    logic [7:0] rd_addr;
    logic [7:0] data_in;
    logic       bit_in;
    logic       wr;
    logic       rd;
    logic       wr_bit;
    logic       rd_bit;
    wire  [7:0] data_out;
    wire        bit_out;
    logic       rst_per;
    logic       rst_cpu;

    int         n_tests = 0;
    int         n_fail  = 0;

    // Reference model: edges since the last sampled request, plus cause bits.
    int         m_d;
    logic [4:0] m_con;
    logic       m_rdv;
    logic [7:0] m_rdd;
    logic [1:0] m_pipe;

    lp805x_rstctl dut (
        .clk         (clk),
        .rsti        (rsti),
        .ext_rst_req (ext_rst_req),
        .wdt_req     (wdt_req),
        .wr_addr     (wr_addr),
        .rd_addr     (rd_addr),
        .data_in     (data_in),
        .bit_in      (bit_in),
        .wr          (wr),
        .rd          (rd),
        .wr_bit      (wr_bit),
        .rd_bit      (rd_bit),
        .data_out    (data_out),
        .bit_out     (bit_out),
        .rst_per     (rst_per),
        .rst_cpu     (rst_cpu)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_d    = 0;
        m_con  = 5'h01;
        m_rdv  = 1'b0;
        m_rdd  = 8'h00;
        m_pipe = 2'b00;
    endtask

    task automatic model_edge();
        logic       ext_s, cfg, sw, mult;
        logic [4:0] clr;
        int         nsrc;
        ext_s  = m_pipe[1];
        m_pipe = {m_pipe[0], ext_rst_req};
        cfg    = wr && !wr_bit && (wr_addr == 8'ha4);
        sw     = cfg && (data_in[7:5] == 3'b101);
        nsrc   = int'(ext_s) + int'(wdt_req) + int'(sw);
        if (rd) begin
            m_rdv = (rd_addr == 8'ha4);
            m_rdd = m_rdv ? {3'b000, m_con} : 8'h00;
        end
        clr  = (cfg && !sw) ? data_in[4:0] : 5'h00;
        mult = (nsrc >= 2) || (nsrc >= 1 && m_con[3:0] != 4'h0);
        m_con = m_con & ~clr;
        if (ext_s)   m_con[1] = 1'b1;
        if (wdt_req) m_con[2] = 1'b1;
        if (sw)      m_con[3] = 1'b1;
        if (mult)    m_con[4] = 1'b1;
        if (nsrc > 0)         m_d = 0;
        else if (m_d < 10000) m_d++;
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model at the
    // rising edge, and return at the next falling edge for sampling.
    task automatic step(input logic ext, input logic wdt, input logic w, input logic wb,
                        input logic [7:0] wa, input logic [7:0] din,
                        input logic r, input logic [7:0] ra);
        ext_rst_req = ext;
        wdt_req     = wdt;
        wr          = w;
        wr_bit      = wb;
        wr_addr     = wa;
        data_in     = din;
        rd          = r;
        rd_addr     = ra;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        wdt_req = 1'b0;
        wr      = 1'b0;
        rd      = 1'b0;
    endtask

    task automatic idle(input logic ext);
        step(ext, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        rsti = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        n_tests++;
        if ({rst_per, rst_cpu} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_hold: rst_per/cpu=%b%b required 11", rst_per, rst_cpu);
        end
        rsti = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            idle(1'b0);
            n_tests++;
            if ({rst_per, rst_cpu} !== {m_d < 16, m_d < 20}) begin
                n_fail++;
                $display("FAIL por_release cyc%0d: rst_per/cpu=%b%b required %b%b",
                         i, rst_per, rst_cpu, m_d < 16, m_d < 20);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'ha4);
        n_tests++;
        if (data_out !== 8'h01) begin
            n_fail++;
            $display("FAIL por_rstcon: got %h required 01", data_out);
        end
    endtask

    task automatic test_wdt();
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        n_tests++;
        if ({rst_per, rst_cpu} !== 2'b11) begin
            n_fail++;
            $display("FAIL wdt_rise: rst_per/cpu=%b%b required 11", rst_per, rst_cpu);
        end
        for (int i = 1; i <= 22; i++) begin
            idle(1'b0);
            n_tests++;
            if ({rst_per, rst_cpu} !== {m_d < 16, m_d < 20}) begin
                n_fail++;
                $display("FAIL wdt_seq cyc%0d: rst_per/cpu=%b%b required %b%b",
                         i, rst_per, rst_cpu, m_d < 16, m_d < 20);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'ha4);
        n_tests++;
        if (data_out !== 8'h15) begin
            n_fail++;
            $display("FAIL wdt_rstcon: got %h required 15", data_out);
        end
    endtask

    task automatic test_sw();
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'ha4, 8'h1f, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'ha4);
        n_tests++;
        if (data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL w1c_all: got %h required 00", data_out);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'ha4, 8'ha0, 1'b0, 8'h00);
        for (int i = 1; i <= 22; i++) begin
            n_tests++;
            if ({rst_per, rst_cpu} !== {m_d < 16, m_d < 20}) begin
                n_fail++;
                $display("FAIL sw_seq cyc%0d: rst_per/cpu=%b%b required %b%b",
                         i, rst_per, rst_cpu, m_d < 16, m_d < 20);
            end
            idle(1'b0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'ha4);
        n_tests++;
        if (data_out !== 8'h08) begin
            n_fail++;
            $display("FAIL sw_rstcon: got %h required 08", data_out);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'ha4, 8'h40, 1'b0, 8'h00);
        for (int i = 1; i <= 4; i++) begin
            n_tests++;
            if ({rst_per, rst_cpu} !== 2'b00) begin
                n_fail++;
                $display("FAIL sw_nokey cyc%0d: rst_per/cpu=%b%b required 00", i, rst_per, rst_cpu);
            end
            idle(1'b0);
        end
    endtask

    task automatic test_ext();
        for (int i = 1; i <= 50; i++) begin
            idle(1'b1);
            n_tests++;
            if ({rst_per, rst_cpu} !== {m_d < 16, m_d < 20}) begin
                n_fail++;
                $display("FAIL ext_hold cyc%0d: rst_per/cpu=%b%b required %b%b",
                         i, rst_per, rst_cpu, m_d < 16, m_d < 20);
            end
        end
        for (int i = 1; i <= 26; i++) begin
            idle(1'b0);
            n_tests++;
            if ({rst_per, rst_cpu} !== {m_d < 16, m_d < 20}) begin
                n_fail++;
                $display("FAIL ext_release cyc%0d: rst_per/cpu=%b%b required %b%b",
                         i, rst_per, rst_cpu, m_d < 16, m_d < 20);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'ha4);
        n_tests++;
        if (data_out !== 8'h1a) begin
            n_fail++;
            $display("FAIL ext_rstcon: got %h required 1a", data_out);
        end
    endtask

    task automatic test_stage_retrigger();
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        repeat (17) idle(1'b0);
        n_tests++;
        if ({rst_per, rst_cpu} !== 2'b01) begin
            n_fail++;
            $display("FAIL stage_state: rst_per/cpu=%b%b required 01", rst_per, rst_cpu);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        for (int i = 1; i <= 22; i++) begin
            n_tests++;
            if ({rst_per, rst_cpu} !== {m_d < 16, m_d < 20}) begin
                n_fail++;
                $display("FAIL stage_restart cyc%0d: rst_per/cpu=%b%b required %b%b",
                         i, rst_per, rst_cpu, m_d < 16, m_d < 20);
            end
            idle(1'b0);
        end
    endtask

    task automatic test_w1c_collision();
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'ha4, 8'h1f, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'ha4);
        n_tests++;
        if (data_out !== 8'h14) begin
            n_fail++;
            $display("FAIL w1c_vs_set: got %h required 14", data_out);
        end
        repeat (22) idle(1'b0);
    endtask

    task automatic test_rsti_mid();
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h10);
        repeat (5) idle(1'b0);
        #2 rsti = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if ({rst_per, rst_cpu} !== 2'b11) begin
            n_fail++;
            $display("FAIL rsti_async: rst_per/cpu=%b%b required 11", rst_per, rst_cpu);
        end
        repeat (2) @(negedge clk);
        rsti = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'ha4);
        n_tests++;
        if (data_out !== 8'h01) begin
            n_fail++;
            $display("FAIL rsti_rstcon: got %h required 01", data_out);
        end
        for (int i = 2; i <= 24; i++) begin
            idle(1'b0);
            n_tests++;
            if ({rst_per, rst_cpu} !== {m_d < 16, m_d < 20}) begin
                n_fail++;
                $display("FAIL rsti_release cyc%0d: rst_per/cpu=%b%b required %b%b",
                         i, rst_per, rst_cpu, m_d < 16, m_d < 20);
            end
        end
    endtask

    task automatic test_random();
        logic       ext, wdt, w, wb, r;
        logic [7:0] wa, din, ra;
        ext = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 39) == 0) ext = ~ext;
            wdt = ($urandom_range(0, 29) == 0);
            w   = ($urandom_range(0, 14) == 0);
            wb  = ($urandom_range(0, 7) == 0);
            wa  = ($urandom_range(0, 3) != 0) ? 8'ha4 : 8'($urandom);
            din = 8'($urandom);
            if ($urandom_range(0, 2) == 0) din[7:5] = 3'b101;
            r   = ($urandom_range(0, 3) == 0);
            ra  = ($urandom_range(0, 2) != 0) ? 8'ha4 : 8'($urandom);
            step(ext, wdt, w, wb, wa, din, r, ra);
            n_tests++;
            if ({rst_per, rst_cpu} !== {m_d < 16, m_d < 20}) begin
                n_fail++;
                $display("FAIL rand_rst cyc%0d: rst_per/cpu=%b%b required %b%b",
                         i, rst_per, rst_cpu, m_d < 16, m_d < 20);
            end
            if (m_rdv) begin
                n_tests++;
                if (data_out !== m_rdd) begin
                    n_fail++;
                    $display("FAIL rand_read cyc%0d: got %h required %h", i, data_out, m_rdd);
                end
            end
        end
        repeat (30) idle(1'b0);
    endtask

    initial begin
        rsti        = 1'b1;
        ext_rst_req = 1'b0;
        wdt_req     = 1'b0;
        wr_addr     = 8'h00;
        rd_addr     = 8'h00;
        data_in     = 8'h00;
        bit_in      = 1'b0;
        wr          = 1'b0;
        rd          = 1'b0;
        wr_bit      = 1'b0;
        rd_bit      = 1'b0;
        @(negedge clk);
        test_reset();
        test_wdt();
        test_sw();
        test_ext();
        test_stage_retrigger();
        test_w1c_collision();
        test_rsti_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
